// File: rtl/mem_access_unit.sv
// mem_access_unit: ARM32 memory stage. Issues LDR/STR over a req/ack data bus,
// stalls upstream while an access is outstanding and records the first fault.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_branch_ref,
  input  logic                  branch_ref,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic [1:0]            ex_size,
  input  logic                  ex_signed,
  input  logic [ADDR_W-1:0]     ex_addr,
  input  logic [31:0]           ex_wdata,
  input  logic [31:0]           ex_result,
  input  logic [3:0]            ex_rd,
  input  logic                  ex_wb_en,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W/8-1:0]   dmem_be,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_en,
  output logic [3:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int TW    = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nx;
  logic                req_nx, we_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [BYTES-1:0]    be_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic                wb_valid_nx, wb_en_nx;
  logic [3:0]          wb_rd_nx;
  logic [31:0]         wb_data_nx;
  logic                err_nx;
  logic [ADDR_W-1:0]   err_addr_nx;

  logic [OFF_W-1:0]    lat_off, off_nx;
  logic [1:0]          lat_size, size_nx;
  logic                lat_signed, signed_nx;
  logic [3:0]          lat_rd, rd_nx;
  logic [TW-1:0]       timer, timer_nx;

  logic [1:0]          ex_sz;
  logic [OFF_W-1:0]    ex_off;
  logic                is_mem, misaligned;
  logic [BYTES-1:0]    be_base;
  logic [31:0]         wdata_low;
  logic [31:0]         rd_shift, ld_val;
  logic                fault;
  logic [ADDR_W-1:0]   fault_addr;

  assign mem_stall = (state == ACCESS);
  assign ex_sz     = (ex_size == 2'b11) ? 2'b10 : ex_size;
  assign ex_off    = ex_addr[OFF_W-1:0];
  assign is_mem    = ex_load | ex_store;
  assign misaligned = ((ex_sz == 2'b01) && ex_addr[0]) ||
                      ((ex_sz == 2'b10) && (ex_addr[1:0] != 2'b00));

  always_comb begin
    be_base   = '0;
    wdata_low = '0;
    case (ex_sz)
      2'b00: begin
        be_base   = BYTES'(4'b0001);
        wdata_low = {24'h0, ex_wdata[7:0]};
      end
      2'b01: begin
        be_base   = BYTES'(4'b0011);
        wdata_low = {16'h0, ex_wdata[15:0]};
      end
      default: begin
        be_base   = BYTES'(4'b1111);
        wdata_low = ex_wdata;
      end
    endcase
  end

  // Load data is pulled down from its byte lane, then extended to 32 bits.
  always_comb begin
    rd_shift = 32'(dmem_rdata >> {lat_off, 3'b000});
    case (lat_size)
      2'b00:   ld_val = {{24{lat_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_val = {{16{lat_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_val = rd_shift;
    endcase
  end

  always_comb begin
    state_nx    = state;
    req_nx      = dmem_req;
    we_nx       = dmem_we;
    addr_nx     = dmem_addr;
    be_nx       = dmem_be;
    wdata_nx    = dmem_wdata;
    wb_valid_nx = 1'b0;
    wb_en_nx    = 1'b0;
    wb_rd_nx    = wb_rd;
    wb_data_nx  = wb_data;
    err_nx      = err;
    err_addr_nx = err_addr;
    off_nx      = lat_off;
    size_nx     = lat_size;
    signed_nx   = lat_signed;
    rd_nx       = lat_rd;
    timer_nx    = timer;
    fault       = 1'b0;
    fault_addr  = '0;

    case (state)
      IDLE: begin
        if (ex_valid && (ex_branch_ref == branch_ref)) begin
          if (!is_mem) begin
            wb_valid_nx = 1'b1;
            wb_en_nx    = ex_wb_en;
            wb_data_nx  = ex_result;
            wb_rd_nx    = ex_rd;
          end else if (misaligned) begin
            wb_valid_nx = 1'b1;
            wb_rd_nx    = ex_rd;
            fault       = 1'b1;
            fault_addr  = ex_addr;
          end else begin
            state_nx  = ACCESS;
            req_nx    = 1'b1;
            we_nx     = ex_store;
            addr_nx   = ex_addr & ~ADDR_W'(BYTES - 1);
            be_nx     = be_base << ex_off;
            wdata_nx  = DATA_W'(wdata_low) << {ex_off, 3'b000};
            off_nx    = ex_off;
            size_nx   = ex_sz;
            signed_nx = ex_signed;
            rd_nx     = ex_rd;
            timer_nx  = '0;
          end
        end
      end
      ACCESS: begin
        // An ack in the final timeout cycle still completes the access.
        if (dmem_ack) begin
          state_nx    = IDLE;
          req_nx      = 1'b0;
          wb_valid_nx = 1'b1;
          wb_rd_nx    = lat_rd;
          if (!dmem_we) begin
            wb_en_nx   = 1'b1;
            wb_data_nx = ld_val;
          end
        end else if ((TIMEOUT > 0) && (timer == TO_LAST)) begin
          state_nx    = IDLE;
          req_nx      = 1'b0;
          wb_valid_nx = 1'b1;
          wb_rd_nx    = lat_rd;
          fault       = 1'b1;
          fault_addr  = dmem_addr | ADDR_W'(lat_off);
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (fault && !err) begin
      err_nx      = 1'b1;
      err_addr_nx = fault_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_en      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_rd     <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nx;
      dmem_req   <= req_nx;
      dmem_we    <= we_nx;
      dmem_addr  <= addr_nx;
      dmem_be    <= be_nx;
      dmem_wdata <= wdata_nx;
      wb_valid   <= wb_valid_nx;
      wb_en      <= wb_en_nx;
      wb_rd      <= wb_rd_nx;
      wb_data    <= wb_data_nx;
      err        <= err_nx;
      err_addr   <= err_addr_nx;
      lat_off    <= off_nx;
      lat_size   <= size_nx;
      lat_signed <= signed_nx;
      lat_rd     <= rd_nx;
      timer      <= timer_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives a 32-bit and a 64-bit instance with identical
// instruction streams and checks both against a byte-lane arithmetic model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        ex_valid, ex_branch_ref, branch_ref, ex_load, ex_store, ex_signed, ex_wb_en;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata, ex_result;
  logic [3:0]  ex_rd;
  logic        dmem_ack;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        stall32, req32, we32, wbv32, wben32, err32;
  logic [31:0] addr32, wdata32, wbdata32, erraddr32;
  logic [3:0]  be32, wbrd32;
  logic        stall64, req64, we64, wbv64, wben64, err64;
  logic [31:0] addr64, wbdata64, erraddr64;
  logic [63:0] wdata64;
  logic [7:0]  be64;
  logic [3:0]  wbrd64;

  int total = 0;
  int bad   = 0;
  logic        exp_err;
  logic [31:0] exp_err_addr;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u32 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch_ref(ex_branch_ref),
    .branch_ref(branch_ref), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
    .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .mem_stall(stall32), .dmem_req(req32),
    .dmem_we(we32), .dmem_addr(addr32), .dmem_be(be32), .dmem_wdata(wdata32),
    .dmem_ack(dmem_ack), .dmem_rdata(rdata32), .wb_valid(wbv32), .wb_en(wben32),
    .wb_rd(wbrd32), .wb_data(wbdata32), .err(err32), .err_addr(erraddr32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u64 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch_ref(ex_branch_ref),
    .branch_ref(branch_ref), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
    .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .mem_stall(stall64), .dmem_req(req64),
    .dmem_we(we64), .dmem_addr(addr64), .dmem_be(be64), .dmem_wdata(wdata64),
    .dmem_ack(dmem_ack), .dmem_rdata(rdata64), .wb_valid(wbv64), .wb_en(wben64),
    .wb_rd(wbrd64), .wb_data(wbdata64), .err(err64), .err_addr(erraddr64)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] exp_be(input int bus, input logic [31:0] addr, input logic [1:0] esz);
    int n, off;
    n   = 1 << esz;
    off = int'(addr % bus);
    return ((64'd1 << n) - 64'd1) << off;
  endfunction

  function automatic logic [63:0] exp_wdata(input int bus, input logic [31:0] addr, input logic [1:0] esz,
                                            input logic [31:0] wd);
    int n, off;
    n   = 1 << esz;
    off = int'(addr % bus);
    return ({32'h0, wd} & ((64'd1 << (8 * n)) - 64'd1)) << (8 * off);
  endfunction

  function automatic logic [31:0] exp_load(input int bus, input logic [63:0] rd, input logic [31:0] addr,
                                           input logic [1:0] esz, input bit sgn);
    int n, off;
    logic [63:0] v;
    n   = 1 << esz;
    off = int'(addr % bus);
    v   = (rd >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    if (sgn && ((v >> (8 * n - 1)) & 64'd1) != 64'd0) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [63:0] o32, input logic [63:0] o64,
                           input logic [63:0] e32, input logic [63:0] e64);
    checkOutput({tag, "_32"}, o32, e32);
    checkOutput({tag, "_64"}, o64, e64);
  endtask

  task automatic checkZero(input string tag);
    checkBoth({tag, "_ctl"}, {stall32, req32, we32, wbv32, wben32, err32, wbrd32, be32},
              {stall64, req64, we64, wbv64, wben64, err64, wbrd64, be64}, 0, 0);
    checkBoth({tag, "_addr"}, addr32, addr64, 0, 0);
    checkBoth({tag, "_wdata"}, wdata32, wdata64, 0, 0);
    checkBoth({tag, "_wbdata"}, wbdata32, wbdata64, 0, 0);
    checkBoth({tag, "_erraddr"}, erraddr32, erraddr64, 0, 0);
  endtask

  task automatic doReset(input string tag);
    rst_n    = 1'b1;
    #1;
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    #2;
    checkZero(tag);
    exp_err      = 1'b0;
    exp_err_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkZero({tag, "_post"});
  endtask

  task automatic idleCycle();
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    checkBoth("bubble_wbv", wbv32, wbv64, 0, 0);
    checkBoth("bubble_req", req32, req64, 0, 0);
  endtask

  task automatic noteFault(input logic [31:0] addr);
    if (!exp_err) begin
      exp_err      = 1'b1;
      exp_err_addr = addr;
    end
    checkBoth("err", err32, err64, 1, 1);
    checkBoth("err_addr", erraddr32, erraddr64, exp_err_addr, exp_err_addr);
  endtask

  // One instruction from presentation to writeback; k = ack delay, k >= TO means no ack.
  task automatic applyStimulus(input bit sq, input bit ld, input bit st, input logic [1:0] sz,
                               input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] res, input logic [3:0] rd, input bit wbe,
                               input int k, input logic [31:0] r32, input logic [63:0] r64);
    logic [1:0] esz;
    int n, waits;
    esz = (sz == 2'b11) ? 2'b10 : sz;
    n   = 1 << esz;
    branch_ref    = 1'($urandom_range(0, 1));
    ex_branch_ref = branch_ref ^ sq;
    ex_valid  = 1'b1;
    ex_load   = ld;
    ex_store  = st;
    ex_size   = sz;
    ex_signed = sgn;
    ex_addr   = addr;
    ex_wdata  = wd;
    ex_result = res;
    ex_rd     = rd;
    ex_wb_en  = wbe;
    @(posedge clk);
    #1;
    if (sq) begin
      checkBoth("squash_wbv", wbv32, wbv64, 0, 0);
      checkBoth("squash_req", req32, req64, 0, 0);
      checkBoth("squash_stall", stall32, stall64, 0, 0);
    end else if (!(ld || st)) begin
      checkBoth("alu_wbv", wbv32, wbv64, 1, 1);
      checkBoth("alu_wben", wben32, wben64, wbe, wbe);
      checkBoth("alu_data", wbdata32, wbdata64, res, res);
      checkBoth("alu_rd", wbrd32, wbrd64, rd, rd);
      checkBoth("alu_stall", stall32, stall64, 0, 0);
    end else if ((addr % n) != 0) begin
      checkBoth("mis_wbv", wbv32, wbv64, 1, 1);
      checkBoth("mis_wben", wben32, wben64, 0, 0);
      checkBoth("mis_req", req32, req64, 0, 0);
      checkBoth("mis_stall", stall32, stall64, 0, 0);
      noteFault(addr);
    end else begin
      checkBoth("iss_req", req32, req64, 1, 1);
      checkBoth("iss_stall", stall32, stall64, 1, 1);
      checkBoth("iss_we", we32, we64, st, st);
      checkBoth("iss_addr", addr32, addr64, addr - (addr % 4), addr - (addr % 8));
      checkBoth("iss_be", be32, be64, exp_be(4, addr, esz), exp_be(8, addr, esz));
      checkBoth("iss_wdata", wdata32, wdata64, exp_wdata(4, addr, esz, wd), exp_wdata(8, addr, esz, wd));
      waits = (k >= TO) ? TO - 1 : k;
      for (int i = 0; i < waits; i++) begin
        branch_ref = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        checkBoth("hold_req", req32, req64, 1, 1);
        checkBoth("hold_stall", stall32, stall64, 1, 1);
      end
      if (k < TO) begin
        dmem_ack = 1'b1;
        rdata32  = r32;
        rdata64  = r64;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        checkBoth("cmp_wbv", wbv32, wbv64, 1, 1);
        checkBoth("cmp_wben", wben32, wben64, !st, !st);
        checkBoth("cmp_rd", wbrd32, wbrd64, rd, rd);
        checkBoth("cmp_req", req32, req64, 0, 0);
        checkBoth("cmp_stall", stall32, stall64, 0, 0);
        if (!st)
          checkBoth("cmp_data", wbdata32, wbdata64,
                    exp_load(4, {32'h0, r32}, addr, esz, sgn), exp_load(8, r64, addr, esz, sgn));
      end else begin
        @(posedge clk);
        #1;
        checkBoth("to_wbv", wbv32, wbv64, 1, 1);
        checkBoth("to_wben", wben32, wben64, 0, 0);
        checkBoth("to_req", req32, req64, 0, 0);
        checkBoth("to_stall", stall32, stall64, 0, 0);
        noteFault(addr);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1;
    ex_valid = 0; ex_branch_ref = 0; branch_ref = 0; ex_load = 0; ex_store = 0;
    ex_size = 0; ex_signed = 0; ex_addr = 0; ex_wdata = 0; ex_result = 0; ex_rd = 0;
    ex_wb_en = 0; dmem_ack = 0; rdata32 = 0; rdata64 = 0;
    exp_err = 0; exp_err_addr = 0;
    $display("[TB] reset and directed loads/stores");
    doReset("rst");
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h100, 0, 0, 4'd7, 0, 2, 32'hDEADBEEF, 64'h01234567_DEADBEEF);
    applyStimulus(0, 0, 1, 2'b00, 0, 32'h103, 32'h123456A5, 0, 4'd2, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'b01, 1, 32'h102, 0, 0, 4'd3, 0, 1, 32'h80010000, 64'h55AA55AA_80010000);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h102, 0, 0, 4'd3, 0, 1, 32'h80010000, 64'h55AA55AA_80010000);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h00C, 0, 0, 4'd9, 0, 3, 32'hCAFEF00D, 64'h89ABCDEF_76543210);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 32'h13572468, 4'd5, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h300, 0, 0, 4'd1, 0, 0, 0, 0);
    $display("[TB] timeout then misaligned faults");
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h200, 0, 0, 4'd4, 0, TO, 0, 0);
    doReset("rst2");
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h101, 0, 0, 4'd6, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2'b01, 0, 32'h203, 32'hFFFF, 0, 4'd6, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'b11, 1, 32'h204, 0, 0, 4'd8, 0, 0, 32'h00000080, 64'h0);
    $display("[TB] randomized stream");
    for (int i = 0; i < 120; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      if ($urandom_range(0, 4) == 0) idleCycle();
      applyStimulus(kind == 0, (kind >= 3) && (kind < 7), kind >= 7, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom, $urandom, 4'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, TO), $urandom,
                    {$urandom, $urandom});
    end
    $display("[TB] reset during access");
    branch_ref = 0; ex_branch_ref = 0; ex_valid = 1; ex_load = 1; ex_store = 0;
    ex_size = 2'b10; ex_addr = 32'h400;
    @(posedge clk);
    #1;
    checkBoth("mid_req", req32, req64, 1, 1);
    doReset("mid_rst");
    checkBoth("mid_wbv", wbv32, wbv64, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
